// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 target committing 16-bit frames into
// five 8-bit control registers that drive the PWM peripheral.
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVR  = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sh;
  logic [SYNC_STAGES-1:0] copi_sh;
  logic [SYNC_STAGES-1:0] ncs_sh;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  logic sclk_d;
  logic copi_d;
  logic ncs_d;

  logic sclk_rise;
  logic ncs_rise;
  logic ncs_fall;

  state_t state;
  state_t state_nx;

  logic        do_clear;
  logic        do_shift;
  logic        do_write;

  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic [6:0]  addr;
  logic [7:0]  data;

  assign sclk_s = sclk_sh[SYNC_STAGES-1];
  assign copi_s = copi_sh[SYNC_STAGES-1];
  assign ncs_s  = ncs_sh[SYNC_STAGES-1];

  assign addr = shreg[14:8];
  assign data = shreg[7:0];

  // Edge pulses are registered, so copi_d lines up with sclk_rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sh   <= '0;
      copi_sh   <= '0;
      ncs_sh    <= '0;
      sclk_d    <= 1'b0;
      copi_d    <= 1'b0;
      ncs_d     <= 1'b0;
      sclk_rise <= 1'b0;
      ncs_rise  <= 1'b0;
      ncs_fall  <= 1'b0;
    end else begin
      sclk_sh   <= {sclk_sh[SYNC_STAGES-2:0], sclk};
      copi_sh   <= {copi_sh[SYNC_STAGES-2:0], copi};
      ncs_sh    <= {ncs_sh[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_s;
      copi_d    <= copi_s;
      ncs_d     <= ncs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      ncs_rise  <= ncs_s & ~ncs_d;
      ncs_fall  <= ~ncs_s & ncs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    do_clear = 1'b0;
    do_shift = 1'b0;
    do_write = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        if (ncs_s) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        if (ncs_fall) begin
          do_clear = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = sclk_rise;
        if (ncs_rise) begin
          state_nx = COMMIT;
        end
      end
      COMMIT: begin
        do_write = (bit_cnt == CNT_FULL)
                 & shreg[15]
                 & (addr <= MAX_ADDR);
        state_nx = IDLE;
      end
      default: begin
        state_nx = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (do_clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (do_shift) begin
      shreg <= {shreg[14:0], copi_d};
      if (bit_cnt != CNT_OVR) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
    end else begin
      wr_strobe <= do_write;
      if (do_write) begin
        case (addr)
          7'h00:   en_reg_out_7_0  <= data;
          7'h01:   en_reg_out_15_8 <= data;
          7'h02:   en_reg_pwm_7_0  <= data;
          7'h03:   en_reg_pwm_15_8 <= data;
          7'h04:   pwm_duty_cycle  <= data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Randomised bench for spi_reg_peripheral with a frame-level
// reference model checked every cycle.
module tb_spi_reg_peripheral;

  localparam int SYNC    = 2;
  localparam int PH_MIN  = SYNC + 1;
  localparam int GAP_MIN = SYNC + 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs  = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       stb;

  spi_reg_peripheral #(
    .SYNC_STAGES (SYNC),
    .MAX_ADDR    (7'h04)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int stb_cnt = 0;

  typedef struct {
    int         due;
    int         addr;
    logic [7:0] data;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] m[5] = '{default: 8'h00};
  bit         dropped = 1'b0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t",
                  nm, act, exp, $time);
  endtask

  // Model: a frame's write lands SYNC+2 edges after ncs is sampled high.
  initial begin
    logic r;
    logic es;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      es = 1'b0;
      if (r) begin
        foreach (m[i]) m[i] = 8'h00;
        pend.delete();
      end else begin
        while (pend.size() > 0 && pend[0].due <= cyc) begin
          m[pend[0].addr] = pend[0].data;
          es = 1'b1;
          void'(pend.pop_front());
        end
      end
      if (stb === 1'b1) stb_cnt++;
      chk("cyc_out70",  r0, m[0]);
      chk("cyc_out158", r1, m[1]);
      chk("cyc_pwm70",  r2, m[2]);
      chk("cyc_pwm158", r3, m[3]);
      chk("cyc_duty",   r4, m[4]);
      chk("cyc_strobe", {7'b0, stb}, {7'b0, es});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    dropped = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] bits,
                            input int nbits,
                            input int ph,
                            input int rst_after);
    logic [6:0] a;
    dropped = 1'b0;
    ncs = 1'b0;
    wait_n(ph);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) pulse_rst();
      copi = bits[nbits-1-i];
      wait_n(ph);
      sclk = 1'b1;
      wait_n(ph);
      sclk = 1'b0;
    end
    wait_n(ph);
    ncs = 1'b1;
    a = bits[14:8];
    if (!dropped && nbits == 16 && bits[15] && a <= 7'h04)
      pend.push_back('{cyc + SYNC + 3, int'(a), bits[7:0]});
  endtask

  task automatic frame(input logic [15:0] w);
    send_frame({16'h0, w}, 16, PH_MIN + 1, -1);
    wait_n(GAP_MIN + 2);
  endtask

  int s0;

  initial begin
    wait_n(3);
    rst = 1'b0;
    wait_n(6);
    chk("rst_out70",  r0, 8'h00);
    chk("rst_out158", r1, 8'h00);
    chk("rst_pwm70",  r2, 8'h00);
    chk("rst_pwm158", r3, 8'h00);
    chk("rst_duty",   r4, 8'h00);
    chk("rst_strobe", {7'b0, stb}, 8'h00);

    s0 = stb_cnt;
    frame(16'h8055);
    wait_n(10);
    chk("t1_out70", r0, 8'h55);
    chk("t1_other", r1 | r2 | r3 | r4, 8'h00);
    chk("t1_nstb", 8'(stb_cnt - s0), 8'd1);

    s0 = stb_cnt;
    frame(16'h84C0);
    wait_n(10);
    chk("t2_duty_c0", r4, 8'hC0);
    frame(16'h84FF);
    wait_n(10);
    chk("t2_duty_ff", r4, 8'hFF);
    chk("t2_nstb", 8'(stb_cnt - s0), 8'd2);

    s0 = stb_cnt;
    frame(16'h0255);
    frame(16'h8A11);
    wait_n(10);
    chk("t3_out70", r0, 8'h55);
    chk("t3_pwm70", r2, 8'h00);
    chk("t3_duty",  r4, 8'hFF);
    chk("t3_nstb", 8'(stb_cnt - s0), 8'd0);

    s0 = stb_cnt;
    send_frame(32'h82AA >> 1, 15, PH_MIN + 1, -1);
    wait_n(GAP_MIN + 2);
    send_frame(32'h82AA << 1, 17, PH_MIN + 1, -1);
    wait_n(GAP_MIN + 10);
    chk("t4_pwm70_bad", r2, 8'h00);
    chk("t4_nstb_bad", 8'(stb_cnt - s0), 8'd0);
    frame(16'h82AA);
    wait_n(10);
    chk("t4_pwm70_ok", r2, 8'hAA);

    s0 = stb_cnt;
    send_frame(32'h83F0, 16, PH_MIN + 1, 8);
    wait_n(GAP_MIN + 10);
    chk("t5_pwm158_drop", r3, 8'h00);
    chk("t5_out70_rst",   r0, 8'h00);
    chk("t5_nstb", 8'(stb_cnt - s0), 8'd0);
    frame(16'h83F0);
    wait_n(10);
    chk("t5_pwm158_ok", r3, 8'hF0);

    s0 = stb_cnt;
    send_frame(32'h8001, 16, PH_MIN, -1);
    wait_n(GAP_MIN);
    send_frame(32'h8102, 16, PH_MIN, -1);
    repeat (SYNC + 2) @(posedge clk);
    #1;
    chk("t6_lat_before", r1, 8'h00);
    @(posedge clk);
    #1;
    chk("t6_lat_after", r1, 8'h02);
    chk("t6_lat_stb", {7'b0, stb}, 8'h01);
    @(negedge clk);
    wait_n(10);
    chk("t6_out70", r0, 8'h01);
    chk("t6_nstb", 8'(stb_cnt - s0), 8'd2);

    for (int k = 0; k < 80; k++) begin
      int kind;
      int ph;
      int nb;
      int ra;
      logic [31:0] w;
      kind = $urandom_range(0, 9);
      ph   = $urandom_range(PH_MIN, PH_MIN + 3);
      w    = $urandom;
      nb   = 16;
      ra   = -1;
      case (kind)
        0, 1, 2, 3, 4:
          w = {16'h0, 1'b1, 7'($urandom_range(0, 4)), w[7:0]};
        5: w = {16'h0, 1'b0, w[14:0]};
        6: w = {16'h0, 1'b1, 7'($urandom_range(5, 127)), w[7:0]};
        7: nb = $urandom_range(0, 15);
        8: nb = $urandom_range(17, 20);
        default: begin
          w  = {16'h0, 1'b1, 7'($urandom_range(0, 4)), w[7:0]};
          ra = $urandom_range(0, 15);
        end
      endcase
      send_frame(w, nb, ph, ra);
      wait_n($urandom_range(GAP_MIN, GAP_MIN + 4));
    end
    wait_n(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
